// File: rtl/uart_param_core.sv
// uart_param_core: parameterised UART with first-word-fall-through TX and RX FIFOs.
//
// A shared baud counter produces a one-clock tick every baud_div+1 clocks. Each
// serial bit lasts 16 ticks. The transmitter pops its FIFO and sends start, data
// (LSB first), optional parity and one or two stop bits. The receiver
// synchronises rx and finds the middle of the start bit. It then samples each
// later bit one bit period apart and pushes good bytes into the RX FIFO.
//
// Optional feature: define UART_PARITY_EN to add a parity bit. This adds the
// parity_odd input and the sticky parity_err output.
//
// Ports:
//   clk, reset          - single clock; asynchronous active-high reset
//   baud_div            - tick period minus one, in clk cycles
//   stop2               - 0: one stop bit, 1: two stop bits (sampled at frame start)
//   tx_data, tx_wr_en   - TX FIFO push; tx_full when no space left
//   tx_busy             - transmitter is inside a frame
//   rx_data, rx_rd_en   - RX FIFO head (valid while rx_empty=0) and pop
//   rx_empty            - RX FIFO holds no data
//   rx_overrun          - sticky: a good byte was dropped because the RX FIFO was full
//   frame_err           - sticky: the first stop bit was sampled low
//   err_clr             - clears the sticky flags (a same-cycle set wins)
//   parity_odd          - (UART_PARITY_EN) 0: even parity, 1: odd parity
//   parity_err          - (UART_PARITY_EN) sticky: received parity mismatch
//   rx, tx              - serial lines, idle high
module uart_param_core #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_WIDTH  = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 stop2,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_wr_en,
  output logic                 tx_full,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_rd_en,
  output logic                 rx_empty,
  output logic                 rx_overrun,
  output logic                 frame_err,
  input  logic                 err_clr,
`ifdef UART_PARITY_EN
  input  logic                 parity_odd,
  output logic                 parity_err,
`endif
  input  logic                 rx,
  output logic                 tx
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);
  localparam logic [2:0]      LastBit   = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  // ---------------------------------------------------------------------------
  // Baud tick
  // ---------------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] baud_cnt_q;
  logic                 tick;

  // '>=' lets the counter recover at once if baud_div is lowered below it.
  assign tick = (baud_cnt_q >= baud_div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt_q <= '0;
    end else if (tick) begin
      baud_cnt_q <= '0;
    end else begin
      baud_cnt_q <= baud_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AddrW-1:0]     tx_wptr_q, tx_rptr_q;
  logic [CntW-1:0]      tx_cnt_q;
  logic                 tx_empty, tx_pop, tx_do_wr, tx_do_rd;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_full  = (tx_cnt_q == FullCount);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_do_wr = tx_wr_en & ~tx_full;
  assign tx_do_rd = tx_pop & ~tx_empty;
  assign tx_head  = tx_mem[tx_rptr_q];

  always_ff @(posedge clk) begin
    if (tx_do_wr) begin
      tx_mem[tx_wptr_q] <= tx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      if (tx_do_wr) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_do_rd) tx_rptr_q <= tx_rptr_q + 1'b1;
      case ({tx_do_wr, tx_do_rd})
        2'b10:   tx_cnt_q <= tx_cnt_q + 1'b1;
        2'b01:   tx_cnt_q <= tx_cnt_q - 1'b1;
        default: tx_cnt_q <= tx_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AddrW-1:0]     rx_wptr_q, rx_rptr_q;
  logic [CntW-1:0]      rx_cnt_q;
  logic                 rx_full, rx_push, rx_do_wr, rx_do_rd;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;

  assign rx_full  = (rx_cnt_q == FullCount);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_do_wr = rx_push & ~rx_full;
  assign rx_do_rd = rx_rd_en & ~rx_empty;
  assign rx_data  = rx_mem[rx_rptr_q];

  always_ff @(posedge clk) begin
    if (rx_do_wr) begin
      rx_mem[rx_wptr_q] <= rx_shift_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (rx_do_wr) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_do_rd) rx_rptr_q <= rx_rptr_q + 1'b1;
      case ({rx_do_wr, rx_do_rd})
        2'b10:   rx_cnt_q <= rx_cnt_q + 1'b1;
        2'b01:   rx_cnt_q <= rx_cnt_q - 1'b1;
        default: rx_cnt_q <= rx_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  state_e               tx_state_q, tx_state_d;
  logic [3:0]           tx_tcnt_q, tx_tcnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_stop2_q, tx_stop2_d;
  logic                 tx_stop_sec_q, tx_stop_sec_d;
  logic                 tx_load;
  logic                 tx_q, tx_d;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  always_comb begin
    tx_state_d    = tx_state_q;
    tx_tcnt_d     = tx_tcnt_q;
    tx_bit_d      = tx_bit_q;
    tx_shift_d    = tx_shift_q;
    tx_stop2_d    = tx_stop2_q;
    tx_stop_sec_d = tx_stop_sec_q;
    tx_load       = 1'b0;
    tx_pop        = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d      = tx_par_q;
`endif
    // The 4-bit tick counter wraps 15 -> 0 exactly when a bit ends.
    unique case (tx_state_q)
      StIdle: begin
        if (tick && !tx_empty) tx_load = 1'b1;
      end
      StStart: begin
        if (tick) begin
          tx_tcnt_d = tx_tcnt_q + 4'd1;
          if (tx_tcnt_q == 4'd15) begin
            tx_state_d = StData;
            tx_bit_d   = '0;
          end
        end
      end
      StData: begin
        if (tick) begin
          tx_tcnt_d = tx_tcnt_q + 4'd1;
          if (tx_tcnt_q == 4'd15) begin
            if (tx_bit_q == LastBit) begin
`ifdef UART_PARITY_EN
              tx_state_d = StParity;
`else
              tx_state_d = StStop;
`endif
              tx_stop_sec_d = 1'b0;
            end else begin
              tx_bit_d   = tx_bit_q + 3'd1;
              tx_shift_d = tx_shift_q >> 1;
            end
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (tick) begin
          tx_tcnt_d = tx_tcnt_q + 4'd1;
          if (tx_tcnt_q == 4'd15) begin
            tx_state_d    = StStop;
            tx_stop_sec_d = 1'b0;
          end
        end
      end
`endif
      StStop: begin
        if (tick) begin
          tx_tcnt_d = tx_tcnt_q + 4'd1;
          if (tx_tcnt_q == 4'd15) begin
            if (tx_stop2_q && !tx_stop_sec_q) begin
              tx_stop_sec_d = 1'b1;
            end else if (!tx_empty) begin
              tx_load = 1'b1; // next frame follows with no idle gap
            end else begin
              tx_state_d = StIdle;
            end
          end
        end
      end
      default: tx_state_d = StIdle;
    endcase

    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_shift_d = tx_head;
      tx_stop2_d = stop2;
      tx_tcnt_d  = '0;
      tx_state_d = StStart;
`ifdef UART_PARITY_EN
      tx_par_d   = (^tx_head) ^ parity_odd;
`endif
    end
  end

  // Line level follows the next state so tx is a clean register output.
  always_comb begin
    tx_d = 1'b1;
    case (tx_state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
      StParity: tx_d = tx_par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q    <= StIdle;
      tx_tcnt_q     <= '0;
      tx_bit_q      <= '0;
      tx_shift_q    <= '0;
      tx_stop2_q    <= 1'b0;
      tx_stop_sec_q <= 1'b0;
      tx_q          <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q      <= 1'b0;
`endif
    end else begin
      tx_state_q    <= tx_state_d;
      tx_tcnt_q     <= tx_tcnt_d;
      tx_bit_q      <= tx_bit_d;
      tx_shift_q    <= tx_shift_d;
      tx_stop2_q    <= tx_stop2_d;
      tx_stop_sec_q <= tx_stop_sec_d;
      tx_q          <= tx_d;
`ifdef UART_PARITY_EN
      tx_par_q      <= tx_par_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (tx_state_q != StIdle);

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic       rx_meta_q, rx_sync_q, rx_prev_q;
  state_e     rx_state_q, rx_state_d;
  logic [3:0] rx_tcnt_q, rx_tcnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic       frame_set, overrun_set;
  logic       frame_err_q, rx_overrun_q;
`ifdef UART_PARITY_EN
  logic       rx_par_q, rx_par_d;
  logic       parity_set, parity_err_q;
`endif

  // Synchroniser flops reset to the idle level so reset release is not seen as
  // a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_tcnt_d   = rx_tcnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_push     = 1'b0;
    frame_set   = 1'b0;
    overrun_set = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_d    = rx_par_q;
    parity_set  = 1'b0;
`endif
    unique case (rx_state_q)
      StIdle: begin
        if (!rx_sync_q && rx_prev_q) begin
          rx_state_d = StStart;
          rx_tcnt_d  = '0;
        end
      end
      StStart: begin
        // Re-check the line half way into the start bit; high means a glitch.
        if (tick) begin
          if (rx_tcnt_q == 4'd7) begin
            rx_tcnt_d = '0;
            if (rx_sync_q) begin
              rx_state_d = StIdle;
            end else begin
              rx_state_d = StData;
              rx_bit_d   = '0;
            end
          end else begin
            rx_tcnt_d = rx_tcnt_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          rx_tcnt_d = rx_tcnt_q + 4'd1;
          if (rx_tcnt_q == 4'd15) begin
            rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == LastBit) begin
`ifdef UART_PARITY_EN
              rx_state_d = StParity;
`else
              rx_state_d = StStop;
`endif
            end else begin
              rx_bit_d = rx_bit_q + 3'd1;
            end
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (tick) begin
          rx_tcnt_d = rx_tcnt_q + 4'd1;
          if (rx_tcnt_q == 4'd15) begin
            rx_par_d   = rx_sync_q;
            rx_state_d = StStop;
          end
        end
      end
`endif
      StStop: begin
        // Only the first stop bit is checked; a second one reads as idle line.
        if (tick) begin
          rx_tcnt_d = rx_tcnt_q + 4'd1;
          if (rx_tcnt_q == 4'd15) begin
            rx_state_d = StIdle;
            if (!rx_sync_q) begin
              frame_set = 1'b1;
`ifdef UART_PARITY_EN
            end else if (((^rx_shift_q) ^ rx_par_q) != parity_odd) begin
              parity_set = 1'b1;
`endif
            end else if (rx_full) begin
              overrun_set = 1'b1;
            end else begin
              rx_push = 1'b1;
            end
          end
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q   <= StIdle;
      rx_tcnt_q    <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      frame_err_q  <= 1'b0;
      rx_overrun_q <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_state_q   <= rx_state_d;
      rx_tcnt_q    <= rx_tcnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      // A set in the same cycle as err_clr wins.
      frame_err_q  <= frame_set | (frame_err_q & ~err_clr);
      rx_overrun_q <= overrun_set | (rx_overrun_q & ~err_clr);
`ifdef UART_PARITY_EN
      rx_par_q     <= rx_par_d;
      parity_err_q <= parity_set | (parity_err_q & ~err_clr);
`endif
    end
  end

  assign frame_err  = frame_err_q;
  assign rx_overrun = rx_overrun_q;
`ifdef UART_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_param_core.sv
// Self-checking bench for uart_param_core (default parameters, no parity).
// Bytes pushed into the transmitter are queued as expected receive data; a
// monitor pops the RX FIFO whenever it is non-empty and compares against the queue.
module tb_uart_param_core;

  localparam int unsigned DivW = 11;

  logic            clk = 1'b0;
  logic            reset;
  logic [DivW-1:0] baud_div;
  logic            stop2;
  logic [7:0]      tx_data;
  logic            tx_wr_en;
  logic            tx_full;
  logic            tx_busy;
  logic [7:0]      rx_data;
  logic            rx_rd_en;
  logic            rx_empty;
  logic            rx_overrun;
  logic            frame_err;
  logic            err_clr;
  logic            rx;
  logic            tx;

  logic loop_en;
  logic rx_drv;
  logic mon_en;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  assign rx = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_param_core #(
    .DATA_BITS (8),
    .FIFO_DEPTH(8),
    .DIV_WIDTH (DivW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .baud_div  (baud_div),
    .stop2     (stop2),
    .tx_data   (tx_data),
    .tx_wr_en  (tx_wr_en),
    .tx_full   (tx_full),
    .tx_busy   (tx_busy),
    .rx_data   (rx_data),
    .rx_rd_en  (rx_rd_en),
    .rx_empty  (rx_empty),
    .rx_overrun(rx_overrun),
    .frame_err (frame_err),
    .err_clr   (err_clr),
    .rx        (rx),
    .tx        (tx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Monitor: pop and compare whenever the RX FIFO presents data.
  initial begin
    rx_rd_en = 1'b0;
    forever begin
      @(negedge clk);
      rx_rd_en = 1'b0;
      if (mon_en && !reset && !rx_empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected actual=%02h required=none", rx_data);
        end else begin
          check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
        rx_rd_en = 1'b1;
      end
    end
  end

  // Push one byte once there is space; optionally record it as expected.
  task automatic send_byte(input logic [7:0] b, input bit expect_rx);
    int n = 0;
    while (tx_full && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (tx_full) bound_fail("tx_full_wait");
    tx_data  = b;
    tx_wr_en = 1'b1;
    if (expect_rx) exp_q.push_back(b);
    @(negedge clk);
    tx_wr_en = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || tx_busy) bound_fail("drain");
    repeat (4) @(negedge clk);
  endtask

  // Transmitter counts as idle after 64 consecutive non-busy cycles.
  task automatic wait_tx_idle();
    int n = 0;
    int run = 0;
    while (run < 64 && n < 20000) begin
      @(negedge clk);
      n++;
      run = tx_busy ? 0 : run + 1;
    end
    if (run < 64) bound_fail("tx_idle");
  endtask

  task automatic wait_tx_fall();
    int n = 0;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) bound_fail("tx_start_edge");
  endtask

  // Drive one frame on rx_drv: start, 8 data bits LSB first, one stop bit of given level.
  task automatic drive_frame(input logic [7:0] b, input logic stop_lvl, input int bit_clks);
    logic [9:0] bits;
    bits = {stop_lvl, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = bits[i];
      repeat (bit_clks) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic err_clear();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] wave;
    logic [7:0] b;
    int bad;

    reset    = 1'b1;
    baud_div = '0;
    stop2    = 1'b0;
    tx_data  = '0;
    tx_wr_en = 1'b0;
    err_clr  = 1'b0;
    loop_en  = 1'b1;
    rx_drv   = 1'b1;
    mon_en   = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_tx_full", {31'd0, tx_full}, 32'd0);
    check("rst_rx_empty", {31'd0, rx_empty}, 32'd1);
    check("rst_rx_overrun", {31'd0, rx_overrun}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Waveform of 0xA5 at one tick per clock: 16 clocks per bit, 160 clocks busy
    baud_div = '0;
    stop2    = 1'b0;
    send_byte(8'hA5, 1'b1);
    wait_tx_fall();
    wave = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bad = 0;
      for (int c = 0; c < 16; c++) begin
        if (tx !== wave[i] || tx_busy !== 1'b1) bad++;
        @(negedge clk);
      end
      check($sformatf("wave_bit%0d_bad_clks", i), bad, 0);
    end
    check("wave_end_tx", {31'd0, tx}, 32'd1);
    check("wave_end_busy", {31'd0, tx_busy}, 32'd0);
    wait_drain();

    // Loopback of two directed bytes at baud_div=3
    baud_div = 11'd3;
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b1);
    wait_drain();
    check("loop_overrun", {31'd0, rx_overrun}, 32'd0);
    check("loop_frame_err", {31'd0, frame_err}, 32'd0);

    // Randomised rounds: random divisor, stop bits and data
    for (int r = 0; r < 4; r++) begin
      baud_div = 11'($urandom_range(0, 2));
      stop2    = 1'($urandom_range(0, 1));
      for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b1);
      wait_drain();
    end
    check("rand_overrun", {31'd0, rx_overrun}, 32'd0);
    check("rand_frame_err", {31'd0, frame_err}, 32'd0);
    stop2 = 1'b0;

    // TX FIFO fill while the first tick is 2048 clocks away: ninth write dropped
    reset    = 1'b1;
    baud_div = 11'd2047;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      b        = 8'($urandom);
      tx_data  = b;
      tx_wr_en = 1'b1;
      if (i < 8) exp_q.push_back(b);
      @(negedge clk);
      if (i == 6) check("fill_not_full_7", {31'd0, tx_full}, 32'd0);
      if (i == 7) check("fill_full_8", {31'd0, tx_full}, 32'd1);
    end
    tx_wr_en = 1'b0;
    check("fill_full_after_9", {31'd0, tx_full}, 32'd1);
    baud_div = 11'd1;
    wait_drain();

    // RX overrun: nine bytes with no reads, first eight kept
    mon_en = 1'b0;
    for (int i = 0; i < 9; i++) send_byte(8'($urandom), i < 8);
    wait_tx_idle();
    check("ovr_set", {31'd0, rx_overrun}, 32'd1);
    check("ovr_no_frame_err", {31'd0, frame_err}, 32'd0);
    check("ovr_not_empty", {31'd0, rx_empty}, 32'd0);
    mon_en = 1'b1;
    wait_drain();
    check("ovr_drained_empty", {31'd0, rx_empty}, 32'd1);
    check("ovr_sticky", {31'd0, rx_overrun}, 32'd1);
    err_clear();
    check("ovr_cleared", {31'd0, rx_overrun}, 32'd0);

    // Framing error: stop bit driven low, 32 clocks per bit at baud_div=1
    loop_en  = 1'b0;
    rx_drv   = 1'b1;
    baud_div = 11'd1;
    repeat (8) @(negedge clk);
    drive_frame(8'($urandom), 1'b0, 32);
    repeat (64) @(negedge clk);
    check("ferr_set", {31'd0, frame_err}, 32'd1);
    check("ferr_rx_empty", {31'd0, rx_empty}, 32'd1);
    check("ferr_no_overrun", {31'd0, rx_overrun}, 32'd0);
    err_clear();
    check("ferr_cleared", {31'd0, frame_err}, 32'd0);

    // Eight-clock low glitch at one tick per clock: false start
    baud_div = '0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b0;
    repeat (8) @(negedge clk);
    rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_rx_empty", {31'd0, rx_empty}, 32'd1);
    check("glitch_frame_err", {31'd0, frame_err}, 32'd0);

    // Externally driven good frame is received
    b = 8'($urandom);
    exp_q.push_back(b);
    drive_frame(b, 1'b1, 16);
    repeat (16) @(negedge clk);
    wait_drain();
    check("ext_frame_err", {31'd0, frame_err}, 32'd0);

    // Reset in the middle of data bit 3 (bit 3 forced to 0 so tx is low there)
    loop_en  = 1'b1;
    baud_div = '0;
    repeat (4) @(negedge clk);
    send_byte(8'($urandom) & 8'hF7, 1'b0);
    wait_tx_fall();
    repeat (72) @(negedge clk);
    check("mid_pre_tx", {31'd0, tx}, 32'd0);
    check("mid_pre_busy", {31'd0, tx_busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
    check("mid_rst_full", {31'd0, tx_full}, 32'd0);
    check("mid_rst_rx_empty", {31'd0, rx_empty}, 32'd1);
    check("mid_rst_overrun", {31'd0, rx_overrun}, 32'd0);
    check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_byte(8'($urandom), 1'b1);
    wait_drain();
    check("post_rst_overrun", {31'd0, rx_overrun}, 32'd0);
    check("post_rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("post_rst_rx_empty", {31'd0, rx_empty}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_param_core.md
UART_PARAM_CORE -- requirements
Module: uart_param_core

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, legal 5..8: data bits per frame.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, power of two >= 2: entries per TX and RX FIFO.
REQ-003 SHALL have parameter DIV_WIDTH, default 11: baud divisor width.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port baud_div, input, DIV_WIDTH: tick period minus one, in clk cycles.
REQ-007 SHALL have port stop2, input, 1: 0 = one stop bit, 1 = two stop bits.
REQ-008 SHALL have ports tx_data (in, DATA_BITS), tx_wr_en (in, 1), tx_full (out, 1), tx_busy (out, 1): push side of the transmitter.
REQ-009 SHALL have ports rx_data (out, DATA_BITS), rx_rd_en (in, 1), rx_empty (out, 1): pop side of the receiver.
REQ-010 SHALL have ports rx_overrun (out, 1), frame_err (out, 1), err_clr (in, 1): sticky error flags and their clear.
REQ-011 SHALL have ports rx (in, 1) and tx (out, 1): serial lines, idle high.

Function
REQ-012 Baud counter SHALL count 0..baud_div; a one-clk tick pulse SHALL fire at terminal count, giving period baud_div+1 clocks; baud_div=0 gives a tick every clock.
REQ-013 Tick SHALL be a clock enable only; no logic clocked by tick.
REQ-014 Each bit SHALL last 16 ticks; stop bits 16 ticks each.
REQ-015 TX FSM SHALL use states IDLE, START, DATA, PARITY (macro only), STOP; IDLE leaves on a tick when the TX FIFO is not empty, popping one entry the same cycle.
REQ-016 TX SHALL send start 0, DATA_BITS LSB-first, optional parity, then 1 or 2 stop bits per stop2 sampled at frame start; tx_busy high outside IDLE.
REQ-017 Back-to-back frames SHALL have no idle gap when the FIFO holds data at STOP end.
REQ-018 RX input SHALL pass through a 2-flop synchroniser before use.
REQ-019 RX SHALL detect a falling edge in IDLE, re-sample at tick 7; if high, false start, return to IDLE, nothing written.
REQ-020 RX SHALL sample each data/parity/stop bit at tick count 15 after the mid-start point.
REQ-021 Stop bit sampled 0 SHALL discard the byte and set frame_err; only the first stop bit is checked.
REQ-022 Good byte with RX FIFO full SHALL be dropped and set rx_overrun; FIFO contents unchanged.
REQ-023 FIFOs SHALL be first-word fall-through: rx_data shows the head while rx_empty=0; rx_rd_en pops.
REQ-024 Write when full or read when empty SHALL be ignored with no pointer or count change.
REQ-025 Simultaneous read and write SHALL both occur when neither is blocked; when empty only write, when full only read; count unchanged on a dual operation.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be $clog2(FIFO_DEPTH)+1 bits.
REQ-027 err_clr SHALL clear sticky flags next cycle; a same-cycle set SHALL win over clear.

Reset
REQ-028 Reset SHALL asynchronously force: tx=1, tx_busy=0, tx_full=0, rx_empty=1, rx_overrun=0, frame_err=0, parity_err=0, both FSMs IDLE, counters and pointers 0.
REQ-029 Reset mid-frame SHALL abort the frame; tx returns high immediately; partial RX byte is lost.
REQ-030 FIFO storage SHALL need no reset; rx_data is don't-care while rx_empty=1.

Configuration
REQ-031 Macro UART_PARITY_EN SHALL add input parity_odd (1) and output parity_err (1, sticky, cleared by err_clr).
REQ-032 With macro: TX sends a parity bit (even when parity_odd=0, odd when 1); RX checks it; a mismatch discards the byte and sets parity_err.
REQ-033 Without macro: no PARITY state, no parity ports, frame length 1+DATA_BITS+stop bits.

Verification
REQ-034 baud_div=0, stop2=0, write 0xA5 -> tx low 16 clk, then 1,0,1,0,0,1,0,1 each 16 clk, high 16 clk; tx_busy high 160 clk.
REQ-035 tx looped to rx, baud_div=3, write 0x3C,0xC3 -> rx_data 0x3C then 0xC3 after pop, no error flags.
REQ-036 FIFO_DEPTH=8: 9 writes while TX idle-blocked -> tx_full after 8th, 9th dropped; 8 bytes emitted in order.
REQ-037 Fill RX FIFO with 8 bytes, send 9th -> rx_overrun=1, 8 original bytes intact; err_clr -> 0.
REQ-038 Drive stop bit 0 on rx -> frame_err=1, rx_empty stays 1; 8-clk rx glitch low -> no byte, no flag.
REQ-039 Reset asserted at DATA bit 3 -> tx=1 same cycle, all outputs at reset values; next write transmits cleanly.
